// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity coding and prescale floor.
// The receive side reuses the same encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_ODD      = 1'b1;
  localparam int   MIN_PRESCALE = 4;

  // Parity bit from the XOR-reduced data word and the parity type.
  function automatic logic parity_bit(input logic data_xor, input logic ptype);
    return (ptype == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter (0..P-1) and data bit index for the UART transmitter.
// Both counters sit at zero whenever their enables are low.
module uart_tx_bit_timer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5,
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_idx_en,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_bit_done,
  output logic [IDX_W-1:0]          o_bit_index
);

  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic [IDX_W-1:0]          r_idx;

  assign o_bit_done  = i_en && (r_cnt == (i_prescale - 1'b1));
  assign o_bit_index = r_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt <= '0;
    end else if (o_bit_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_idx_en) begin
      r_idx <= '0;
    end else if (o_bit_done) begin
      r_idx <= (r_idx == IDX_W'(DATA_WIDTH - 1)) ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, data LSB first, optional parity, stop bit.
// Each bit is held for max(Prescale, MIN_PRESCALE) clock cycles; outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_WIDTH-1:0] MIN_P = PRESCALE_WIDTH'(MIN_PRESCALE);

  uart_state_t               r_state, w_state_next;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_parity;
  logic                      r_par_en;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_tx, w_tx_next;
  logic                      r_busy, w_busy_next;
  logic                      w_accept, w_shift;
  logic                      w_bit_done;
  logic [IDX_W-1:0]          w_bit_index;
  logic                      w_last_bit;

  uart_tx_bit_timer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_timer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_en       (r_state != IDLE),
    .i_idx_en   (r_state == DATA),
    .i_prescale (r_prescale),
    .o_bit_done (w_bit_done),
    .o_bit_index(w_bit_index)
  );

  assign w_last_bit = (w_bit_index == IDX_W'(DATA_WIDTH - 1));

  // Next TX_OUT is chosen from the bit about to start, so the line changes only at bit edges.
  always_comb begin
    w_state_next = r_state;
    w_tx_next    = r_tx;
    w_busy_next  = r_busy;
    w_accept     = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        if (Data_Valid) begin
          w_accept     = 1'b1;
          w_state_next = START;
          w_tx_next    = 1'b0;
          w_busy_next  = 1'b1;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_next = DATA;
          w_tx_next    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_done) begin
          if (w_last_bit) begin
            w_state_next = r_par_en ? PARITY : STOP;
            w_tx_next    = r_par_en ? r_parity : 1'b1;
          end else begin
            w_shift   = 1'b1;
            w_tx_next = r_shift[1];
          end
        end
      end
      PARITY: begin
        if (w_bit_done) begin
          w_state_next = STOP;
          w_tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (w_bit_done) begin
          w_state_next = IDLE;
          w_tx_next    = 1'b1;
          w_busy_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_par_en   <= 1'b0;
      r_prescale <= '0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_busy  <= w_busy_next;
      if (w_accept) begin
        r_shift    <= P_DATA;
        r_parity   <= parity_bit(^P_DATA, parity_type);
        r_par_en   <= parity_enable;
        r_prescale <= (Prescale < MIN_P) ? MIN_P : Prescale;
      end else if (w_shift) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of whole frames with hand-computed bit patterns,
// plus hand-written reset-mid-frame and back-to-back sequences.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       parity_enable;
  logic       parity_type;
  logic [4:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .parity_enable(parity_enable),
    .parity_type  (parity_type),
    .Prescale     (Prescale),
    .TX_OUT       (TX_OUT),
    .busy         (busy)
  );

  // frame[i] is the i-th bit on the line (start bit first); hook_kind:
  // 0 none, 1 inject 0x55 request, 2 change Prescale to 16, 3 drop Data_Valid.
  typedef struct {
    logic [4:0]  presc;
    logic        pe;
    logic        pt;
    logic [7:0]  data;
    int          p;
    int          nb;
    logic [15:0] frame;
    int          hook_at;
    int          hook_kind;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s idle busy c%0d", tag, i), busy, 1'b0);
      chk($sformatf("%s idle tx c%0d", tag, i), TX_OUT, 1'b1);
      @(negedge CLK);
    end
  endtask

  // Issue a request at the current negedge; returns at the first frame cycle (T+1).
  task automatic request(input logic [4:0] presc, input logic pe, input logic pt,
                         input logic [7:0] d, input logic hold);
    Prescale      = presc;
    parity_enable = pe;
    parity_type   = pt;
    P_DATA        = d;
    Data_Valid    = 1'b1;
    @(negedge CLK);
    if (!hold) begin
      Data_Valid    = 1'b0;
      P_DATA        = ~d;
      parity_type   = ~pt;
      parity_enable = ~pe;
      Prescale      = 5'd31;
    end
  endtask

  task automatic watch_frame(input string tag, input int p, input int nb,
                             input logic [15:0] frame, input int hook_at, input int hook_kind);
    for (int i = 0; i < p * nb; i++) begin
      chk($sformatf("%s busy c%0d", tag, i), busy, 1'b1);
      chk($sformatf("%s tx c%0d", tag, i), TX_OUT, frame[i / p]);
      if (i == hook_at) begin
        case (hook_kind)
          1: begin P_DATA = 8'h55; Data_Valid = 1'b1; end
          2: Prescale = 5'd16;
          3: Data_Valid = 1'b0;
          default: ;
        endcase
      end
      if (hook_kind == 1 && i == hook_at + 1) Data_Valid = 1'b0;
      @(negedge CLK);
    end
    chk($sformatf("%s end busy", tag), busy, 1'b0);
    chk($sformatf("%s end tx", tag), TX_OUT, 1'b1);
    $display("frame %s: P=%0d bits=%0d pattern=%h", tag, p, nb, frame);
  endtask

  initial begin
    vecs[0] = '{5'd8,  1'b1, 1'b0, 8'hA5, 8,  11, 16'h054A, -1, 0};
    vecs[1] = '{5'd8,  1'b1, 1'b1, 8'hA5, 8,  11, 16'h074A, -1, 0};
    vecs[2] = '{5'd16, 1'b0, 1'b0, 8'h3C, 16, 10, 16'h0278, -1, 0};
    vecs[3] = '{5'd8,  1'b1, 1'b0, 8'hA5, 8,  11, 16'h054A, 20, 1};
    vecs[4] = '{5'd2,  1'b0, 1'b0, 8'h01, 4,  10, 16'h0202, -1, 0};
    vecs[5] = '{5'd0,  1'b1, 1'b1, 8'hFF, 4,  11, 16'h07FE, -1, 0};

    RST = 1'b1; Data_Valid = 1'b0; P_DATA = 8'h00;
    parity_enable = 1'b0; parity_type = 1'b0; Prescale = 5'd8;
    repeat (3) @(negedge CLK);
    chk("reset busy", busy, 1'b0);
    chk("reset tx", TX_OUT, 1'b1);
    RST = 1'b0;
    idle_check("post-reset", 3);

    for (int v = 0; v < 6; v++) begin
      request(vecs[v].presc, vecs[v].pe, vecs[v].pt, vecs[v].data, 1'b0);
      watch_frame($sformatf("vec%0d", v), vecs[v].p, vecs[v].nb, vecs[v].frame,
                  vecs[v].hook_at, vecs[v].hook_kind);
      idle_check($sformatf("vec%0d", v), 20);
    end

    // Reset in the middle of the data bits, with a request present on the same edge.
    request(5'd8, 1'b1, 1'b0, 8'hA5, 1'b0);
    for (int i = 0; i < 30; i++) begin
      chk($sformatf("pre-rst tx c%0d", i), TX_OUT, vecs[0].frame[i / 8]);
      @(negedge CLK);
    end
    RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h55;
    @(negedge CLK);
    chk("mid-rst busy", busy, 1'b0);
    chk("mid-rst tx", TX_OUT, 1'b1);
    RST = 1'b0; Data_Valid = 1'b0;
    idle_check("after-rst", 3);
    request(5'd8, 1'b0, 1'b0, 8'h81, 1'b0);
    watch_frame("post-rst 0x81", 8, 10, 16'h0302, -1, 0);
    idle_check("post-rst", 3);

    // Back-to-back with Data_Valid held; Prescale changes mid-frame.
    request(5'd8, 1'b0, 1'b0, 8'h3C, 1'b1);
    watch_frame("b2b first", 8, 10, 16'h0278, 10, 2);
    @(negedge CLK);
    watch_frame("b2b second", 16, 10, 16'h0278, 5, 3);
    idle_check("b2b", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
